// File: rtl/soc_top_pkg.sv
// rtl/soc_top_pkg.sv - command opcodes and UART engine state encoding shared by soc_top and soc_uart
package soc_top_pkg;

  localparam logic [3:0] CMD_LED_HI = 4'hA;
  localparam logic [7:0] CMD_STATUS = 8'hB0;
  localparam logic [7:0] CMD_CLR    = 8'hC0;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

endpackage

// File: rtl/soc_uart.sv
// rtl/soc_uart.sv - 8N1 UART receive and transmit engines, CLK_DIV clocks per bit
module soc_uart
  import soc_top_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic       o_rx_valid,
  output logic [7:0] o_rx_data,
  output logic       o_frame_err,
  input  logic       i_tx_req,
  input  logic [7:0] i_tx_data,
  output logic       o_tx_busy,
  output logic       o_tx
);

  localparam logic [15:0] FULL = 16'(CLK_DIV - 1);
  localparam logic [15:0] HALF = 16'(CLK_DIV / 2 - 1);

  uart_state_e r_rx_state;
  logic [15:0] r_rx_cnt;
  logic [2:0]  r_rx_bit;
  logic [7:0]  r_rx_sh;
  logic        r_rx_wait;
  logic        r_rx_valid;
  logic        r_frame_err;

  // r_rx_wait holds the receiver off until the line has been seen high (after reset or a bad stop bit)
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_state  <= IDLE;
      r_rx_cnt    <= '0;
      r_rx_bit    <= '0;
      r_rx_sh     <= '0;
      r_rx_wait   <= 1'b1;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_rx_state)
        IDLE: begin
          r_rx_cnt <= '0;
          r_rx_bit <= '0;
          if (r_rx_wait)
            r_rx_wait <= !i_rx;
          else if (!i_rx)
            r_rx_state <= START;
        end
        START: begin
          if (r_rx_cnt == HALF) begin
            r_rx_cnt   <= '0;
            r_rx_state <= i_rx ? IDLE : DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + 16'd1;
          end
        end
        DATA: begin
          if (r_rx_cnt == FULL) begin
            r_rx_cnt <= '0;
            r_rx_sh  <= {i_rx, r_rx_sh[7:1]};
            r_rx_bit <= r_rx_bit + 3'd1;
            if (r_rx_bit == 3'd7)
              r_rx_state <= STOP;
          end else begin
            r_rx_cnt <= r_rx_cnt + 16'd1;
          end
        end
        STOP: begin
          if (r_rx_cnt == FULL) begin
            r_rx_cnt   <= '0;
            r_rx_state <= IDLE;
            if (i_rx) begin
              r_rx_valid <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
              r_rx_wait   <= 1'b1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + 16'd1;
          end
        end
        default: r_rx_state <= IDLE;
      endcase
    end
  end

  assign o_rx_valid  = r_rx_valid;
  assign o_rx_data   = r_rx_sh;
  assign o_frame_err = r_frame_err;

  uart_state_e r_tx_state;
  logic [15:0] r_tx_cnt;
  logic [2:0]  r_tx_bit;
  logic [7:0]  r_tx_sh;
  logic        r_tx;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tx_state <= IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_sh    <= '0;
      r_tx       <= 1'b1;
    end else begin
      case (r_tx_state)
        IDLE: begin
          r_tx_cnt <= '0;
          r_tx_bit <= '0;
          if (i_tx_req) begin
            r_tx_sh    <= i_tx_data;
            r_tx       <= 1'b0;
            r_tx_state <= START;
          end
        end
        START: begin
          if (r_tx_cnt == FULL) begin
            r_tx_cnt   <= '0;
            r_tx       <= r_tx_sh[0];
            r_tx_sh    <= {1'b0, r_tx_sh[7:1]};
            r_tx_state <= DATA;
          end else begin
            r_tx_cnt <= r_tx_cnt + 16'd1;
          end
        end
        DATA: begin
          if (r_tx_cnt == FULL) begin
            r_tx_cnt <= '0;
            r_tx_bit <= r_tx_bit + 3'd1;
            if (r_tx_bit == 3'd7) begin
              r_tx       <= 1'b1;
              r_tx_state <= STOP;
            end else begin
              r_tx    <= r_tx_sh[0];
              r_tx_sh <= {1'b0, r_tx_sh[7:1]};
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + 16'd1;
          end
        end
        STOP: begin
          if (r_tx_cnt == FULL)
            r_tx_state <= IDLE;
          else
            r_tx_cnt <= r_tx_cnt + 16'd1;
        end
        default: r_tx_state <= IDLE;
      endcase
    end
  end

  assign o_tx_busy = (r_tx_state != IDLE);
  assign o_tx      = r_tx;

endmodule

// File: rtl/soc_top.sv
// rtl/soc_top.sv - reset control, input sync, UART command decoder, LED/error registers, heartbeat
// Heartbeat counter on gpio_out[5] is built only when SOC_HEARTBEAT_EN is defined.
module soc_top
  import soc_top_pkg::*;
#(
  parameter int CLK_DIV = 16,
  parameter int HB_DIV  = 1000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] externalPins_gpio_in,
  input  logic       externalPins_uart_rx,
  output logic [5:0] externalPins_gpio_out,
  output logic       externalPins_uart_tx
);

  logic       w_rst_src_n;
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  assign w_rst_src_n = reset & externalPins_gpio_in[0];

  // Either source clears the chain at once; release ripples through two flops
  always_ff @(posedge clock or negedge w_rst_src_n) begin
    if (!w_rst_src_n)
      r_rst_sync <= 2'b00;
    else
      r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  logic [1:0] r_rx_sync;
  logic [2:0] r_gpio_s1;
  logic [2:0] r_gpio_s2;

  always_ff @(posedge clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_rx_sync <= 2'b00;
      r_gpio_s1 <= '0;
      r_gpio_s2 <= '0;
    end else begin
      r_rx_sync <= {r_rx_sync[0], externalPins_uart_rx};
      r_gpio_s1 <= externalPins_gpio_in[3:1];
      r_gpio_s2 <= r_gpio_s1;
    end
  end

  logic       w_rx_valid;
  logic [7:0] w_rx_data;
  logic       w_frame_err;
  logic       w_tx_busy;
  logic       w_tx;
  logic       w_tx_req;
  logic [7:0] w_resp;
  logic       w_err;
  logic       w_clr;
  logic       w_drop;
  logic       w_hb;

  logic [3:0] r_led;
  logic       r_frame_err;
  logic       r_overrun;

  assign w_err    = r_frame_err | r_overrun;
  assign w_clr    = w_rx_valid && (w_rx_data == CMD_CLR);
  assign w_resp   = (w_rx_data == CMD_STATUS) ? {r_gpio_s2, w_err, r_led} : w_rx_data;
  assign w_tx_req = w_rx_valid & ~w_tx_busy;
  assign w_drop   = w_rx_valid & w_tx_busy;

  soc_uart #(
    .CLK_DIV(CLK_DIV)
  ) u_uart (
    .i_clk      (clock),
    .i_rst_n    (w_rst_n),
    .i_rx       (r_rx_sync[1]),
    .o_rx_valid (w_rx_valid),
    .o_rx_data  (w_rx_data),
    .o_frame_err(w_frame_err),
    .i_tx_req   (w_tx_req),
    .i_tx_data  (w_resp),
    .o_tx_busy  (w_tx_busy),
    .o_tx       (w_tx)
  );

  // A clear command beats a simultaneous framing error; a dropped echo re-flags overrun
  always_ff @(posedge clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_led       <= '0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_rx_valid && (w_rx_data[7:4] == CMD_LED_HI))
        r_led <= w_rx_data[3:0];
      if (w_clr)
        r_frame_err <= 1'b0;
      else if (w_frame_err)
        r_frame_err <= 1'b1;
      if (w_drop)
        r_overrun <= 1'b1;
      else if (w_clr)
        r_overrun <= 1'b0;
    end
  end

`ifdef SOC_HEARTBEAT_EN
  localparam int HB_W = (HB_DIV > 1) ? $clog2(HB_DIV) : 1;
  logic [HB_W-1:0] r_hb_cnt;
  logic            r_hb;

  always_ff @(posedge clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_hb_cnt <= '0;
      r_hb     <= 1'b0;
    end else if (r_hb_cnt == HB_W'(HB_DIV - 1)) begin
      r_hb_cnt <= '0;
      r_hb     <= ~r_hb;
    end else begin
      r_hb_cnt <= r_hb_cnt + HB_W'(1);
    end
  end

  assign w_hb = r_hb;
`else
  assign w_hb = 1'b0;
`endif

  assign externalPins_gpio_out = {w_hb, w_err, r_led};
  assign externalPins_uart_tx  = w_tx;

endmodule

// File: tb/tb_soc_top.sv
// tb/tb_soc_top.sv - directed UART command vectors against a transaction-level model of soc_top
module tb_soc_top;
  import soc_top_pkg::*;

  localparam int CLK_DIV = 16;
  localparam int HALF    = CLK_DIV / 2;
  localparam int HB_DIV  = 10;
  localparam int FRAME   = 10 * CLK_DIV;
  localparam int LAT_MIN = 9 * CLK_DIV + HALF;
  localparam int LAT_MAX = 9 * CLK_DIV + HALF + 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] gpio_in = 4'b0001;
  logic       uart_rx = 1'b1;
  logic [5:0] gpio_out;
  logic       uart_tx;

  soc_top #(.CLK_DIV(CLK_DIV), .HB_DIV(HB_DIV)) dut (
    .clock                (clock),
    .reset                (reset),
    .externalPins_gpio_in (gpio_in),
    .externalPins_uart_rx (uart_rx),
    .externalPins_gpio_out(gpio_out),
    .externalPins_uart_tx (uart_tx)
  );

  always #10 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model: LED/error registers and the expected echo stream
  logic [3:0] m_led = 4'h0;
  bit         m_ferr = 1'b0;
  bit         m_ovr = 1'b0;
  int         last_req = -1000000;
  logic [7:0] exp_q[$];

  task automatic model_rx(input logic [7:0] b, input int t);
    logic [7:0] resp;
    resp = b;
    if (b[7:4] == CMD_LED_HI) m_led = b[3:0];
    if (b == CMD_STATUS) resp = {gpio_in[3:1], m_ferr | m_ovr, m_led};
    if (b == CMD_CLR) begin
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
    end
    if (t - last_req <= FRAME) begin
      m_ovr = 1'b1;
    end else begin
      exp_q.push_back(resp);
      last_req = t;
    end
  endtask

  task automatic model_reset();
    m_led = 4'h0;
    m_ferr = 1'b0;
    m_ovr = 1'b0;
    last_req = -1000000;
    exp_q.delete();
  endtask

  bit         chk_en = 1'b0;
  logic [4:0] cmp_exp;
  always @(negedge clock) begin
    if (chk_en) begin
      cmp_exp = {m_ferr | m_ovr, m_led};
      check("gpio_out[4:0] vs model", gpio_out[4:0], cmp_exp);
`ifndef SOC_HEARTBEAT_EN
      check("heartbeat disabled", gpio_out[5], 1'b0);
`endif
    end
  end

  // TX line monitor: decodes every frame, samples at bit centres
  bit         mon_en = 1'b0;
  int         mon_bad = 0;
  int         mon_t0;
  bit         mon_ok;
  logic [7:0] mon_b;
  logic [7:0] got_q[$];
  int         got_t[$];

  always begin
    @(negedge clock);
    if (mon_en && uart_tx === 1'b0) begin
      mon_t0 = cyc;
      repeat (HALF) @(negedge clock);
      mon_ok = (uart_tx === 1'b0);
      for (int i = 0; i < 8; i++) begin
        repeat (CLK_DIV) @(negedge clock);
        mon_b[i] = uart_tx;
      end
      repeat (CLK_DIV) @(negedge clock);
      mon_ok = mon_ok && (uart_tx === 1'b1);
      if (!mon_ok) mon_bad++;
      got_q.push_back(mon_b);
      got_t.push_back(mon_t0);
    end
  end

  function automatic logic [7:0] got0();
    return (got_q.size() > 0) ? got_q[0] : 8'hxx;
  endfunction

  task automatic check_tx(input string name);
    check({name, " tx byte count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({name, " tx byte"}, got_q.pop_front(), exp_q.pop_front());
    check({name, " tx framing errors"}, mon_bad, 0);
    got_q.delete();
    got_t.delete();
    exp_q.delete();
    mon_bad = 0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  int last_start;

  // Callers are always parked 1 time unit after a rising edge, so consecutive sends have zero gap
  task automatic send_byte(input logic [7:0] b);
    chk_en = 1'b0;
    last_start = cyc;
    uart_rx = 1'b0;
    wait_cycles(CLK_DIV);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      wait_cycles(CLK_DIV);
    end
    uart_rx = 1'b1;
    wait_cycles(CLK_DIV);
    model_rx(b, last_start);
    chk_en = 1'b1;
  endtask

  task automatic settle();
    wait_cycles(12 * CLK_DIV);
  endtask

  task automatic pulse_button(input string name);
    chk_en = 1'b0;
    #3 gpio_in[0] = 1'b0;
    #5;
    check({name, " gpio_out during pulse"}, gpio_out, 6'h00);
    check({name, " uart_tx during pulse"}, uart_tx, 1'b1);
    #5 gpio_in[0] = 1'b1;
    model_reset();
    @(posedge clock);
    #1;
    wait_cycles(1);
    check({name, " gpio_out after release"}, gpio_out, 6'h00);
    check({name, " uart_tx after release"}, uart_tx, 1'b1);
  endtask

  task automatic hb_edge(output int t);
    logic p;
    int k;
    p = gpio_out[5];
    k = 0;
    while (gpio_out[5] === p && k < 4 * HB_DIV) begin
      @(negedge clock);
      k++;
    end
    t = (k < 4 * HB_DIV) ? cyc : -1000;
  endtask

  int lat;
  int t1, t2, t3;

  initial begin
    wait_cycles(3);
    check("power-on gpio_out", gpio_out, 6'h00);
    check("power-on uart_tx", uart_tx, 1'b1);
    reset = 1'b1;
    wait_cycles(5);
    check("post-reset gpio_out", gpio_out, 6'h00);
    check("post-reset uart_tx", uart_tx, 1'b1);
    mon_en = 1'b1;
    chk_en = 1'b1;

    send_byte(8'hA5);
    settle();
    check("LED after 0xA5", gpio_out[3:0], 4'h5);
    lat = (got_t.size() > 0) ? got_t[0] - last_start : -1;
    n_vec++;
    if (lat < LAT_MIN || lat > LAT_MAX) begin
      n_err++;
      $display("FAIL echo latency: got %0d cycles, expected %0d..%0d", lat, LAT_MIN, LAT_MAX);
    end
    check_tx("0xA5");

    send_byte(8'h3C);
    settle();
    check_tx("0x3C");

    gpio_in = 4'b1011;
    send_byte(8'hA3);
    settle();
    check_tx("0xA3");
    send_byte(CMD_STATUS);
    settle();
    check("status byte literal", got0(), 8'hA3);
    check_tx("status");

    uart_rx = 1'b0;
    wait_cycles(4);
    uart_rx = 1'b1;
    settle();
    check_tx("start glitch");
    send_byte(8'h5A);
    settle();
    check_tx("0x5A after glitch");

    chk_en = 1'b0;
    uart_rx = 1'b0;
    wait_cycles(10000);
    check("stuck-low error bit", gpio_out[4], 1'b1);
    check("stuck-low no tx", got_q.size(), 0);
    uart_rx = 1'b1;
    m_ferr = 1'b1;
    wait_cycles(4);
    chk_en = 1'b1;
    send_byte(CMD_STATUS);
    settle();
    check("status with error literal", got0(), 8'hB3);
    check_tx("status with error");
    send_byte(CMD_CLR);
    settle();
    check("error after clear", gpio_out[4], 1'b0);
    check_tx("clear");

    send_byte(8'h11);
    send_byte(8'h22);
    settle();
    check("overrun bit", gpio_out[4], 1'b1);
    check_tx("back-to-back");
    send_byte(CMD_CLR);
    settle();
    check_tx("clear overrun");

    chk_en = 1'b0;
    uart_rx = 1'b0;
    wait_cycles(3 * CLK_DIV);
    pulse_button("reset mid-rx");
    wait_cycles(3 * CLK_DIV);
    uart_rx = 1'b1;
    settle();
    check_tx("reset mid-rx");
    chk_en = 1'b1;

    send_byte(8'hA7);
    check("tx in start bit", uart_tx, 1'b0);
    pulse_button("reset mid-tx");
    settle();
    got_q.delete();
    got_t.delete();
    mon_bad = 0;
    chk_en = 1'b1;
    wait_cycles(4);

`ifdef SOC_HEARTBEAT_EN
    hb_edge(t1);
    hb_edge(t2);
    hb_edge(t3);
    check("heartbeat half period", t2 - t1, HB_DIV);
    check("heartbeat period", t3 - t1, 2 * HB_DIV);
`else
    wait_cycles(5 * HB_DIV);
    check("heartbeat stays low", gpio_out[5], 1'b0);
`endif

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
